// File: rtl/synch_fifo.sv
// Single-clock FIFO with full/empty status and registered overflow/underflow pulses.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module synch_fifo #(
  parameter  int DEPTH      = 16,
  parameter  int DATA_WIDTH = 8,
  localparam int DATA_PTR   = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  full_o,
  output logic                  overflow_o,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  empty_o,
  output logic                  underflow_o
);

  logic [DATA_PTR:0]     r_wr_ptr;
  logic [DATA_PTR:0]     r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_ovf;
  logic                  r_udf;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;
  logic w_wr_rej;
  logic w_rd_rej;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[DATA_PTR] != r_rd_ptr[DATA_PTR]) &&
                   (r_wr_ptr[DATA_PTR-1:0] == r_rd_ptr[DATA_PTR-1:0]);

  // Memory has no reset, so gate its write enable while reset is held.
  assign w_wr_acc = rst && wr_en_i && !w_full;
  assign w_rd_acc = rd_en_i && !w_empty;
  assign w_wr_rej = wr_en_i && w_full;
  assign w_rd_rej = rd_en_i && w_empty;

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr[DATA_PTR-1:0]] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_rdata  <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      r_ovf <= w_wr_rej;
      r_udf <= w_rd_rej;
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + (DATA_PTR+1)'(1);
      end
      if (w_rd_acc) begin
        r_rdata  <= r_mem[r_rd_ptr[DATA_PTR-1:0]];
        r_rd_ptr <= r_rd_ptr + (DATA_PTR+1)'(1);
      end
    end
  end

  assign full_o      = w_full;
  assign empty_o     = w_empty;
  assign rdata_o     = r_rdata;
  assign overflow_o  = r_ovf;
  assign underflow_o = r_udf;

endmodule

// File: tb/tb_synch_fifo.sv
// Randomized bench for synch_fifo against a queue-based reference model.
// Each scenario task drives the DUT and checks its outputs inline.
module tb_synch_fifo;

  localparam int DEPTH = 16;
  localparam int DW    = 8;

  logic          clk;
  logic          rst;
  logic          wr_en_i;
  logic [DW-1:0] wdata_i;
  logic          full_o;
  logic          overflow_o;
  logic          rd_en_i;
  logic [DW-1:0] rdata_o;
  logic          empty_o;
  logic          underflow_o;

  synch_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (wr_en_i),
    .wdata_i    (wdata_i),
    .full_o     (full_o),
    .overflow_o (overflow_o),
    .rd_en_i    (rd_en_i),
    .rdata_o    (rdata_o),
    .empty_o    (empty_o),
    .underflow_o(underflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rdata;
  bit            m_ovf;
  bit            m_udf;
  int            n_chk;
  int            n_fail;

  task automatic model_reset();
    q.delete();
    m_rdata = '0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
  endtask

  // One clock: apply inputs, advance the model on the edge, sample 1ns later.
  task automatic cyc(input bit w, input bit r, input logic [DW-1:0] d);
    bit f;
    bit e;
    wr_en_i = w;
    rd_en_i = r;
    wdata_i = d;
    f = (q.size() == DEPTH);
    e = (q.size() == 0);
    @(posedge clk);
    m_ovf = w && f;
    m_udf = r && e;
    if (r && !e) m_rdata = q.pop_front();
    if (w && !f) q.push_back(d);
    #1;
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
    wdata_i = '0;
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    n_chk++;
    if (empty_o !== 1'b1 || full_o !== 1'b0 || rdata_o !== 8'h00 ||
        overflow_o !== 1'b0 || underflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: e=%b f=%b rd=%h o=%b u=%b want 1 0 00 0 0",
               empty_o, full_o, rdata_o, overflow_o, underflow_o);
    end
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (empty_o !== 1'b1 || full_o !== 1'b0 || rdata_o !== 8'h00 ||
        overflow_o !== 1'b0 || underflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_held: e=%b f=%b rd=%h o=%b u=%b want 1 0 00 0 0",
               empty_o, full_o, rdata_o, overflow_o, underflow_o);
    end
    rst = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DEPTH; i++) begin
      cyc(1'b1, 1'b0, DW'(i));
      n_chk++;
      if (empty_o !== 1'b0 || overflow_o !== 1'b0) begin
        n_fail++;
        $display("FAIL fill_empty_ovf: i=%0d e=%b o=%b want 0 0",
                 i, empty_o, overflow_o);
      end
      n_chk++;
      if (full_o !== (i == DEPTH)) begin
        n_fail++;
        $display("FAIL fill_full: i=%0d got %b want %b", i, full_o, i == DEPTH);
      end
    end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= DEPTH; i++) begin
      cyc(1'b0, 1'b1, '0);
      n_chk++;
      if (rdata_o !== DW'(i) || rdata_o !== m_rdata) begin
        n_fail++;
        $display("FAIL drain_data: i=%0d got %h want %h", i, rdata_o, DW'(i));
      end
      n_chk++;
      if (empty_o !== (i == DEPTH) || full_o !== 1'b0 || underflow_o !== 1'b0) begin
        n_fail++;
        $display("FAIL drain_status: i=%0d e=%b f=%b u=%b want %b 0 0",
                 i, empty_o, full_o, underflow_o, i == DEPTH);
      end
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= DEPTH + 3; i++) begin
      cyc(1'b1, 1'b0, DW'(i));
      n_chk++;
      if (overflow_o !== (i > DEPTH) || overflow_o !== m_ovf) begin
        n_fail++;
        $display("FAIL ovf_flag: i=%0d got %b want %b", i, overflow_o, i > DEPTH);
      end
    end
    cyc(1'b0, 1'b0, '0);
    n_chk++;
    if (overflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: got %b want 0", overflow_o);
    end
    for (int i = 1; i <= DEPTH; i++) begin
      cyc(1'b0, 1'b1, '0);
      n_chk++;
      if (rdata_o !== DW'(i)) begin
        n_fail++;
        $display("FAIL ovf_data: i=%0d got %h want %h", i, rdata_o, DW'(i));
      end
    end
    n_chk++;
    if (empty_o !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_lost: empty got %b want 1", empty_o);
    end
  endtask

  task automatic test_underflow();
    for (int i = 1; i <= DEPTH; i++) cyc(1'b1, 1'b0, DW'(i));
    for (int i = 1; i <= DEPTH + 2; i++) begin
      cyc(1'b0, 1'b1, '0);
      n_chk++;
      if (rdata_o !== ((i > DEPTH) ? 8'h10 : DW'(i))) begin
        n_fail++;
        $display("FAIL udf_data: i=%0d got %h want %h", i, rdata_o,
                 (i > DEPTH) ? 8'h10 : DW'(i));
      end
      n_chk++;
      if (underflow_o !== (i > DEPTH) || underflow_o !== m_udf) begin
        n_fail++;
        $display("FAIL udf_flag: i=%0d got %b want %b", i, underflow_o, i > DEPTH);
      end
    end
    cyc(1'b0, 1'b0, '0);
    n_chk++;
    if (underflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL udf_clear: got %b want 0", underflow_o);
    end
  endtask

  task automatic test_simul_full();
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, DW'(8'hA0 + i));
    cyc(1'b1, 1'b1, 8'h55);
    n_chk++;
    if (rdata_o !== 8'hA0 || overflow_o !== 1'b1 || full_o !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_full: rd=%h o=%b f=%b want a0 1 0",
               rdata_o, overflow_o, full_o);
    end
    for (int i = 1; i < DEPTH; i++) cyc(1'b0, 1'b1, '0);
    n_chk++;
    if (rdata_o !== 8'hAF || empty_o !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_full_drain: rd=%h e=%b want af 1", rdata_o, empty_o);
    end
  endtask

  task automatic test_simul_empty();
    cyc(1'b1, 1'b1, 8'h77);
    n_chk++;
    if (underflow_o !== 1'b1 || empty_o !== 1'b0 || rdata_o !== 8'hAF) begin
      n_fail++;
      $display("FAIL simul_empty: u=%b e=%b rd=%h want 1 0 af",
               underflow_o, empty_o, rdata_o);
    end
    cyc(1'b0, 1'b1, '0);
    n_chk++;
    if (rdata_o !== 8'h77 || empty_o !== 1'b1 || underflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_empty_rd: rd=%h e=%b u=%b want 77 1 0",
               rdata_o, empty_o, underflow_o);
    end
  endtask

  task automatic test_wrap();
    cyc(1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 1'b1, 8'($urandom));
      n_chk++;
      if (rdata_o !== m_rdata || empty_o !== 1'b0 || full_o !== 1'b0) begin
        n_fail++;
        $display("FAIL wrap: i=%0d rd=%h want %h e=%b f=%b",
                 i, rdata_o, m_rdata, empty_o, full_o);
      end
    end
    cyc(1'b0, 1'b1, '0);
    n_chk++;
    if (rdata_o !== m_rdata || empty_o !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_end: rd=%h want %h e=%b", rdata_o, m_rdata, empty_o);
    end
  endtask

  task automatic test_random();
    int wp;
    int rp;
    for (int i = 0; i < 600; i++) begin
      wp = (i / 150) % 2 == 0 ? 70 : 35;
      rp = 100 - wp;
      cyc($urandom_range(99) < wp, $urandom_range(99) < rp, 8'($urandom));
      n_chk++;
      if (rdata_o !== m_rdata || overflow_o !== m_ovf || underflow_o !== m_udf ||
          full_o !== (q.size() == DEPTH) || empty_o !== (q.size() == 0)) begin
        n_fail++;
        $display("FAIL random: i=%0d rd=%h/%h o=%b/%b u=%b/%b f=%b e=%b n=%0d",
                 i, rdata_o, m_rdata, overflow_o, m_ovf, underflow_o, m_udf,
                 full_o, empty_o, q.size());
      end
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, DW'(8'hC0 + i));
    cyc(1'b0, 1'b1, '0);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    n_chk++;
    if (empty_o !== 1'b1 || full_o !== 1'b0 || rdata_o !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_reset: e=%b f=%b rd=%h want 1 0 00",
               empty_o, full_o, rdata_o);
    end
    cyc(1'b1, 1'b1, 8'hEE);
    n_chk++;
    if (empty_o !== 1'b1 || underflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_ignore: e=%b u=%b want 1 0", empty_o, underflow_o);
    end
    rst = 1'b1;
    cyc(1'b1, 1'b0, 8'h3C);
    cyc(1'b0, 1'b1, '0);
    n_chk++;
    if (rdata_o !== 8'h3C || empty_o !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset: rd=%h e=%b want 3c 1", rdata_o, empty_o);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_fill();
    test_drain();
    test_overflow();
    test_underflow();
    test_simul_full();
    test_simul_empty();
    test_wrap();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
